// File: rtl/fifo_tx_arbiter_pkg.sv
// Shared types and constants for the fifo_tx_arbiter transmit-side arbiter.
package fifo_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2
  } arb_state_e;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;
  localparam int         GAP_MIN     = 3;
  localparam int         IDX_W       = 3;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational rotate-priority select: the first valid index at or after ptr_i wins.
module fifo_rr_pick
  import fifo_tx_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o   = '0;
    grant_o = '0;
    any_o   = |valid_i;
    // Walk offsets from farthest to nearest so the nearest valid index is the last write.
    for (int i = N - 1; i >= 0; i--) begin
      for (int k = 0; k < N; k++) begin
        if (valid_i[k] && ((int'(ptr_i) + i == k) || (int'(ptr_i) + i == k + N))) begin
          idx_o = IDX_W'(k);
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      if (any_o && (idx_o == IDX_W'(k))) grant_o[k] = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_tx_arbiter.sv
// Round-robin byte arbiter feeding fifo_interface with paced single-cycle tx strobes.
// Optional retry of a byte that saw tx_err_i: define FIFO_ARB_ERR_RETRY_EN.
module fifo_tx_arbiter
  import fifo_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 878,
  parameter int CNT_W      = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   tx_data_rdy_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_err_i,
  output logic [IDX_W-1:0]       grant_id_o,
  output logic [7:0]             err_count_o,
  output logic                   busy_o,
  output logic [1:0]             state_dbg_o
);

  // Handshake: requester k hands over its byte in the cycle where req_valid_i[k] and
  // req_ready_o[k] are both high. Ready is only raised in IDLE, is one-hot, may depend
  // on valid, and valid may drop at any time before it is accepted.

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - GAP_MIN);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        data_q;
  logic [IDX_W-1:0]  gid_q;
  logic [7:0]        err_q;
  logic              accept;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [7:0]         pick_byte;

  fifo_rr_pick #(.N(NUM_REQ)) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    pick_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) pick_byte = req_data_i[8*k +: 8];
    end
  end

`ifdef FIFO_ARB_ERR_RETRY_EN
  logic retry_q, retried_q, rt_wait_q, retry_pend;

  // A byte gets at most one retry; errors during its retry are only counted.
  assign retry_pend = retry_q | (tx_err_i & ~retried_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      retry_q   <= 1'b0;
      retried_q <= 1'b0;
      rt_wait_q <= 1'b0;
    end else begin
      rt_wait_q <= 1'b0;
      if (accept) begin
        retry_q   <= 1'b0;
        retried_q <= 1'b0;
      end else if (state_q == ST_STROBE) begin
        if (retry_q) begin
          retry_q   <= 1'b0;
          retried_q <= 1'b1;
        end else begin
          retry_q <= retry_pend;
        end
      end else if (state_q == ST_GAP) begin
        retry_q <= retry_pend;
        // One extra GAP cycle keeps the retry strobe exactly GAP_CYCLES after the original.
        rt_wait_q <= (cnt_q == '0) && retry_pend && !rt_wait_q;
      end
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    req_ready_o   = '0;
    tx_data_rdy_o = 1'b0;
    accept        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any && !reset_i) begin
          req_ready_o = pick_grant;
          accept      = 1'b1;
          state_d     = ST_STROBE;
        end
      end
      ST_STROBE: begin
        tx_data_rdy_o = 1'b1;
        state_d       = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
`ifdef FIFO_ARB_ERR_RETRY_EN
          if (rt_wait_q)        state_d = ST_STROBE;
          else if (!retry_pend) state_d = ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      gid_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= pick_byte;
        gid_q  <= pick_idx;
        ptr_q  <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (state_q == ST_STROBE)                  cnt_q <= GAP_LOAD;
      else if (state_q == ST_GAP && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      if (tx_err_i && err_q != ERR_CNT_MAX)      err_q <= err_q + 1'b1;
    end
  end

  assign tx_data_o   = data_q;
  assign grant_id_o  = gid_q;
  assign err_count_o = err_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_fifo_tx_arbiter.sv
// Directed bench for fifo_tx_arbiter with NUM_REQ=4, GAP_CYCLES=8.
module tb_fifo_tx_arbiter;
  import fifo_tx_arbiter_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int GAP_CYCLES = 8;

  logic                 clk_i = 1'b0;
  logic                 reset_i = 1'b1;
  logic [NUM_REQ-1:0]   req_valid_i = '0;
  logic [8*NUM_REQ-1:0] req_data_i = '0;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic                 tx_data_rdy_o;
  logic [7:0]           tx_data_o;
  logic                 tx_err_i = 1'b0;
  logic [2:0]           grant_id_o;
  logic [7:0]           err_count_o;
  logic                 busy_o;
  logic [1:0]           state_dbg_o;

  int checks = 0;
  int errors = 0;

  // Clock and reset
  always #5 clk_i = ~clk_i;

  fifo_tx_arbiter #(.NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP_CYCLES), .CNT_W(16)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .req_valid_i   (req_valid_i),
    .req_data_i    (req_data_i),
    .req_ready_o   (req_ready_o),
    .tx_data_rdy_o (tx_data_rdy_o),
    .tx_data_o     (tx_data_o),
    .tx_err_i      (tx_err_i),
    .grant_id_o    (grant_id_o),
    .err_count_o   (err_count_o),
    .busy_o        (busy_o),
    .state_dbg_o   (state_dbg_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_reset();
    reset_i     = 1'b1;
    req_valid_i = '0;
    tx_err_i    = 1'b0;
    cyc();
    cyc();
    reset_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 40) begin
      cyc();
      n++;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy_o=%b still high after 40 cycles, want 0", name, busy_o);
    end
  endtask

  task automatic test_reset();
    reset_i     = 1'b1;
    req_valid_i = 4'b1111;
    req_data_i  = 32'hDEADBEEF;
    cyc(); cyc(); cyc();
    settle();
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b want 0000", req_ready_o); end
    checks++; if (tx_data_rdy_o !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b want 0", tx_data_rdy_o); end
    checks++; if (tx_data_o !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", tx_data_o); end
    checks++; if (grant_id_o !== 3'd0) begin errors++; $display("FAIL rst_gid: got %0d want 0", grant_id_o); end
    checks++; if (err_count_o !== 8'h00) begin errors++; $display("FAIL rst_err: got %h want 00", err_count_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    checks++; if (state_dbg_o !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state_dbg_o); end
    req_valid_i = '0;
    reset_i     = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    req_data_i  = 32'h0000_0041;
    req_valid_i = 4'b0001;
    settle();
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL t1_ready: got %b want 0001", req_ready_o); end
    cyc();
    req_valid_i = '0;
    settle();
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL t1_ready_off: got %b want 0000", req_ready_o); end
    checks++; if (tx_data_rdy_o !== 1'b1) begin errors++; $display("FAIL t1_strobe: got %b want 1", tx_data_rdy_o); end
    checks++; if (tx_data_o !== 8'h41) begin errors++; $display("FAIL t1_data: got %h want 41", tx_data_o); end
    checks++; if (grant_id_o !== 3'd0) begin errors++; $display("FAIL t1_gid: got %0d want 0", grant_id_o); end
    cyc();
    checks++; if (tx_data_rdy_o !== 1'b0) begin errors++; $display("FAIL t1_one_cycle: got %b want 0", tx_data_rdy_o); end
    for (int c = 3; c <= 7; c++) begin
      cyc();
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t1_busy_c%0d: got %b want 1", c, busy_o); end
    end
    cyc();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t1_idle_t8: got %b want 0", busy_o); end
    checks++; if (tx_data_o !== 8'h41) begin errors++; $display("FAIL t1_data_hold: got %h want 41", tx_data_o); end
  endtask

  task automatic test_round_robin();
    logic       exp_rdy;
    logic [3:0] exp_ready;
    logic [7:0] exp_byte;
    apply_reset();
    req_data_i  = 32'h1312_1110;
    req_valid_i = 4'b1111;
    settle();
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL rr_ready_t0: got %b want 0001", req_ready_o); end
    for (int c = 1; c <= 33; c++) begin
      cyc();
      exp_rdy   = (c % 8 == 1);
      exp_ready = (c % 8 == 0) ? (4'b0001 << ((c / 8) % 4)) : 4'b0000;
      checks++; if (tx_data_rdy_o !== exp_rdy) begin errors++; $display("FAIL rr_strobe_t%0d: got %b want %b", c, tx_data_rdy_o, exp_rdy); end
      checks++; if (req_ready_o !== exp_ready) begin errors++; $display("FAIL rr_ready_t%0d: got %b want %b", c, req_ready_o, exp_ready); end
      if (exp_rdy) begin
        exp_byte = 8'h10 + 8'((c / 8) % 4);
        checks++; if (tx_data_o !== exp_byte) begin errors++; $display("FAIL rr_data_t%0d: got %h want %h", c, tx_data_o, exp_byte); end
        checks++; if (grant_id_o !== 3'((c / 8) % 4)) begin errors++; $display("FAIL rr_gid_t%0d: got %0d want %0d", c, grant_id_o, (c / 8) % 4); end
      end
    end
    req_valid_i = '0;
    wait_idle("rr_idle");
  endtask

  task automatic test_pointer_wrap();
    apply_reset();
    req_data_i  = 32'hA300_22A0;
    req_valid_i = 4'b0100;
    settle();
    checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL pw_ready_req2: got %b want 0100", req_ready_o); end
    cyc();
    req_valid_i = '0;
    wait_idle("pw_idle1");
    req_valid_i = 4'b1001;
    settle();
    checks++; if (req_ready_o !== 4'b1000) begin errors++; $display("FAIL pw_ready_req3: got %b want 1000", req_ready_o); end
    cyc();
    checks++; if (tx_data_rdy_o !== 1'b1 || tx_data_o !== 8'hA3 || grant_id_o !== 3'd3) begin
      errors++; $display("FAIL pw_strobe3: got rdy=%b data=%h gid=%0d want 1 A3 3", tx_data_rdy_o, tx_data_o, grant_id_o);
    end
    repeat (7) cyc();
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL pw_ready_req0: got %b want 0001", req_ready_o); end
    cyc();
    req_valid_i = '0;
    settle();
    checks++; if (tx_data_rdy_o !== 1'b1 || tx_data_o !== 8'hA0 || grant_id_o !== 3'd0) begin
      errors++; $display("FAIL pw_strobe0: got rdy=%b data=%h gid=%0d want 1 A0 0", tx_data_rdy_o, tx_data_o, grant_id_o);
    end
    wait_idle("pw_idle2");
  endtask

  task automatic test_err();
    logic [3:0] exp_r8;
    logic       exp_busy8;
    logic [7:0] exp_byte;
    logic [2:0] exp_gid;
`ifdef FIFO_ARB_ERR_RETRY_EN
    exp_r8 = 4'b0000; exp_busy8 = 1'b1; exp_byte = 8'h55; exp_gid = 3'd1;
`else
    exp_r8 = 4'b0100; exp_busy8 = 1'b0; exp_byte = 8'h66; exp_gid = 3'd2;
`endif
    apply_reset();
    req_data_i  = 32'h0066_5500;
    req_valid_i = 4'b0010;
    settle();
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL er_ready: got %b want 0010", req_ready_o); end
    cyc();
    req_valid_i = 4'b0110;
    settle();
    checks++; if (tx_data_rdy_o !== 1'b1 || tx_data_o !== 8'h55 || grant_id_o !== 3'd1) begin
      errors++; $display("FAIL er_strobe1: got rdy=%b data=%h gid=%0d want 1 55 1", tx_data_rdy_o, tx_data_o, grant_id_o);
    end
    cyc(); cyc();
    tx_err_i = 1'b1;
    cyc();
    tx_err_i = 1'b0;
    cyc();
    checks++; if (err_count_o !== 8'd1) begin errors++; $display("FAIL er_count: got %0d want 1", err_count_o); end
    cyc(); cyc(); cyc();
    checks++; if (req_ready_o !== exp_r8) begin errors++; $display("FAIL er_ready_t8: got %b want %b", req_ready_o, exp_r8); end
    checks++; if (busy_o !== exp_busy8) begin errors++; $display("FAIL er_busy_t8: got %b want %b", busy_o, exp_busy8); end
    cyc();
    req_valid_i = '0;
    settle();
    checks++; if (tx_data_rdy_o !== 1'b1) begin errors++; $display("FAIL er_strobe2: got %b want 1", tx_data_rdy_o); end
    checks++; if (tx_data_o !== exp_byte) begin errors++; $display("FAIL er_data2: got %h want %h", tx_data_o, exp_byte); end
    checks++; if (grant_id_o !== exp_gid) begin errors++; $display("FAIL er_gid2: got %0d want %0d", grant_id_o, exp_gid); end
    wait_idle("er_idle");
  endtask

  task automatic test_reset_mid_gap();
    apply_reset();
    req_data_i  = 32'hB322_B100;
    req_valid_i = 4'b0100;
    settle();
    checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL rm_ready_req2: got %b want 0100", req_ready_o); end
    repeat (5) cyc();
    checks++; if (state_dbg_o !== 2'd2) begin errors++; $display("FAIL rm_in_gap: got state %0d want 2", state_dbg_o); end
    reset_i = 1'b1;
    cyc();
    settle();
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL rm_ready: got %b want 0000", req_ready_o); end
    checks++; if (tx_data_rdy_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rm_ctrl: got rdy=%b busy=%b want 0 0", tx_data_rdy_o, busy_o); end
    checks++; if (tx_data_o !== 8'h00 || grant_id_o !== 3'd0) begin errors++; $display("FAIL rm_data: got data=%h gid=%0d want 00 0", tx_data_o, grant_id_o); end
    cyc();
    reset_i     = 1'b0;
    req_valid_i = 4'b1010;
    settle();
    checks++; if (tx_data_rdy_o !== 1'b0) begin errors++; $display("FAIL rm_no_strobe: got %b want 0", tx_data_rdy_o); end
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL rm_ptr0: got %b want 0010", req_ready_o); end
    cyc();
    req_valid_i = '0;
    settle();
    checks++; if (tx_data_rdy_o !== 1'b1 || tx_data_o !== 8'hB1 || grant_id_o !== 3'd1) begin
      errors++; $display("FAIL rm_strobe: got rdy=%b data=%h gid=%0d want 1 B1 1", tx_data_rdy_o, tx_data_o, grant_id_o);
    end
    wait_idle("rm_idle");
  endtask

  task automatic test_err_saturate();
    apply_reset();
    tx_err_i = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      cyc();
      if (c == 100 || c == 254) begin
        checks++; if (err_count_o !== 8'(c)) begin errors++; $display("FAIL sat_count_c%0d: got %0d want %0d", c, err_count_o, c); end
      end
    end
    checks++; if (err_count_o !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %h want FF", err_count_o); end
    tx_err_i = 1'b0;
    cyc();
    checks++; if (err_count_o !== 8'hFF) begin errors++; $display("FAIL sat_after: got %h want FF", err_count_o); end
    tx_err_i = 1'b1;
    reset_i  = 1'b1;
    cyc();
    checks++; if (err_count_o !== 8'h00) begin errors++; $display("FAIL sat_reset_wins: got %h want 00", err_count_o); end
    tx_err_i = 1'b0;
    reset_i  = 1'b0;
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_wrap();
    test_err();
    test_reset_mid_gap();
    test_err_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
